// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: runs base/ext/yellow intervals back-to-back in whole
// one-second ticks and pulses expired once per finished interval and once
// after reset (the kickoff).
//
// Ports:
//   clk            single clock, rising edge
//   globalReset_n  asynchronous active-low reset
//   tickIn         external one-cycle tick (only with INTERVAL_TIMER_EXT_TICK_EN)
//   enableTimer    level; high runs intervals back-to-back, low stops
//   intervalSel    00 base, 01 ext, 10 yellow, 11 treated as base
//   reprogram      one-cycle write strobe for the interval registers
//   paramSel       write target: 00 base, 01 ext, 10 yellow, 11 none
//   timeValue      value written on reprogram
//   expired        one-cycle pulse per completed interval and after reset
//   timeLeft       remaining whole ticks of the running interval, else 0
//   running        high while loading or counting
//
// Configuration macro: INTERVAL_TIMER_EXT_TICK_EN
//   undefined: internal prescaler of CLK_PER_TICK cycles makes the tick
//   defined:   prescaler removed, tickIn supplies the tick
module interval_timer_ctrl #(
    parameter int unsigned CLK_PER_TICK = 100000000,
    parameter int unsigned TIME_W       = 4
) (
    input  logic              clk,
    input  logic              globalReset_n,
`ifdef INTERVAL_TIMER_EXT_TICK_EN
    input  logic              tickIn,
`endif
    input  logic              enableTimer,
    input  logic [1:0]        intervalSel,
    input  logic              reprogram,
    input  logic [1:0]        paramSel,
    input  logic [TIME_W-1:0] timeValue,
    output logic              expired,
    output logic [TIME_W-1:0] timeLeft,
    output logic              running
);

    typedef enum logic [2:0] {
        S_KICK,
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_EXP
    } state_t;

    state_t            state, state_d;
    logic [TIME_W-1:0] base_q, ext_q, yellow_q;
    logic [TIME_W-1:0] base_d, ext_d, yellow_d;
    logic [TIME_W-1:0] time_left_d;
    logic              expired_d, running_d;
    logic [TIME_W-1:0] sel_val_c, load_val_c;
    logic              tick_c, wr_c;

`ifdef INTERVAL_TIMER_EXT_TICK_EN
    // Ticks outside COUNT are ignored, so the first tick after LOAD counts.
    assign tick_c = tickIn && (state == S_COUNT);
`else
    localparam int unsigned PRE_W = $clog2(CLK_PER_TICK);

    logic [PRE_W-1:0] pre_q, pre_d;

    assign tick_c = (state == S_COUNT) && (pre_q == PRE_W'(CLK_PER_TICK - 1));

    // Prescaler runs only while counting on; wraps on tick, zero elsewhere.
    always_comb begin
        pre_d = '0;
        if ((state == S_COUNT) && (state_d == S_COUNT) && !tick_c) begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge globalReset_n) begin
        if (!globalReset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`endif

    assign wr_c = reprogram && (paramSel != 2'b11);

    // Interval selection; a stored 0 still runs for one tick.
    always_comb begin
        case (intervalSel)
            2'b01:   sel_val_c = ext_q;
            2'b10:   sel_val_c = yellow_q;
            default: sel_val_c = base_q;
        endcase
        load_val_c = (sel_val_c == '0) ? TIME_W'(1) : sel_val_c;
    end

    // Next state, register writes and next output values.
    always_comb begin
        state_d     = state;
        base_d      = base_q;
        ext_d       = ext_q;
        yellow_d    = yellow_q;
        time_left_d = timeLeft;
        expired_d   = 1'b0;

        case (state)
            S_KICK: begin
                state_d   = S_IDLE;
                expired_d = 1'b1;
            end
            S_IDLE: begin
                if (enableTimer) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (enableTimer) begin
                    state_d     = S_COUNT;
                    time_left_d = load_val_c;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COUNT: begin
                if (!enableTimer) begin
                    state_d = S_IDLE;
                end else if (tick_c) begin
                    if (timeLeft == TIME_W'(1)) begin
                        state_d   = S_EXP;
                        expired_d = 1'b1;
                    end else begin
                        time_left_d = timeLeft - TIME_W'(1);
                    end
                end
            end
            S_EXP: begin
                state_d = enableTimer ? S_LOAD : S_IDLE;
            end
            default: begin
                state_d = S_KICK;
            end
        endcase

        // A valid write wins over everything and aborts the running interval.
        if (wr_c) begin
            state_d   = S_IDLE;
            expired_d = 1'b0;
            case (paramSel)
                2'b00:   base_d   = timeValue;
                2'b01:   ext_d    = timeValue;
                default: yellow_d = timeValue;
            endcase
        end

        if (state_d != S_COUNT) time_left_d = '0;
        running_d = (state_d == S_LOAD) || (state_d == S_COUNT);
    end

    always_ff @(posedge clk or negedge globalReset_n) begin
        if (!globalReset_n) begin
            state    <= S_KICK;
            base_q   <= TIME_W'(6);
            ext_q    <= TIME_W'(3);
            yellow_q <= TIME_W'(2);
            timeLeft <= '0;
            expired  <= 1'b0;
            running  <= 1'b0;
        end else begin
            state    <= state_d;
            base_q   <= base_d;
            ext_q    <= ext_d;
            yellow_q <= yellow_d;
            timeLeft <= time_left_d;
            expired  <= expired_d;
            running  <= running_d;
        end
    end

endmodule
